cla_sub_seq: RTL and testbench
==============================

Name: cla_sub_seq

Overview:
- Multi-cycle N-bit subtractor. It computes A − B − Bin four bits per clock using a 4-bit borrow-lookahead slice.
- It is the inverse-direction companion of the team's 4-bit carry-lookahead adder.
- It sits on a valid/ready stream between operand producers and the ALU result path, so wide subtracts and compares reuse one small slice instead of a full-width array.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived; number of 4-bit slice cycles per operation. Not overridable.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands on a, b, bin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).
- zero  output  1  diff == 0.
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, zero=0, ovf=0, slice counter=0, internal borrow=0. Reset mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid & in_ready: latch a, b, bin into operand registers; borrow=bin; counter=0; go to CALC.
- CALC:
  - in_ready=0, out_valid=0.
  - Each cycle processes slice k = counter, bits [4k+3:4k].
  - Per bit: g = ~a & b; p = ~(a ^ b).
  - Borrows by lookahead from the slice borrow-in: br1 = g0 | p0&bi; br2 = g1 | p1&g0 | p1&p0&bi; br3 and br4 are the analogous full expansions.
  - Diff bit j = a_j ^ b_j ^ br_j, with br0 = bi.
  - Write the diff nibble into the result register at slice k; borrow <= br4; counter++.
  - After slice NSLICE−1: drive bout=br4; zero and ovf from the full result; go to DONE.
- DONE:
  - out_valid=1; diff/bout/zero/ovf held stable while out_ready=0.
  - On the edge with out_ready=1: out_valid drops, state goes to IDLE, in_ready=1 the following cycle.
  - Result registers keep their last value after hand-off, until overwritten.
- Latency: out_valid rises NSLICE edges after the accepting edge; with WIDTH=16, 4 cycles.
- Throughput: one operation per NSLICE+2 cycles at best.
- No new operand is accepted while in CALC or DONE, so in_valid held high waits.
- in_valid/out_ready combinations outside IDLE/DONE are ignored.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- Wrap-around: 0 − 1 gives diff = all ones, bout=1.
- bin=1 with a==b gives diff = all ones, bout=1, zero=0.

Test Plan:
- WIDTH=16: a=0x1234, b=0x0234, bin=0, accept at cycle 0 → out_valid at edge 4; diff=0x1000, bout=0, zero=0, ovf=0.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, zero=0, ovf=0; then a=0x5555, b=0x5555, bin=0 → diff=0x0000, zero=1, bout=0.
- a=0x8000, b=0x0001 → diff=0x7FFF, ovf=1, bout=0; a=0x7FFF, b=0xFFFF → diff=0x8000, ovf=1, bout=1.
- Hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0, a second in_valid is not accepted. Raise out_ready → out_valid=0 next cycle, in_ready=1, then the pending operand is accepted.
- Assert rst for 1 cycle at slice 2 of an operation → immediate IDLE, all outputs 0. Next operation a=0x00FF, b=0x000F, bin=1 → diff=0x00EF, bout=0.
- Borrow chain across all slices: a=0x1000, b=0x0FFF, bin=1 → diff=0x0000, zero=1, bout=0. Scoreboard also runs 1000 random operands and checks against an ideal-arithmetic reference model (diff, bout, zero, ovf).

Source files
------------

// File: rtl/cla_sub_seq.sv
// cla_sub_seq: multi-cycle subtractor computing (a - b - bin) mod 2^WIDTH.
// The operands pass through one 4-bit borrow-lookahead slice, four bits per
// clock, least significant nibble first. The block has a valid/ready input
// port and a valid/ready result port. WIDTH must be a multiple of 4 and at
// least 4.

module cla_sub_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    // Number of slice cycles per operation. This value is derived from WIDTH
    // and cannot be overridden.
    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NSLICE - 1);

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // 4-bit borrow lookahead. A bit generates a borrow when it computes 0 - 1.
    // A bit propagates the incoming borrow when its two operand bits are equal.
    // The result holds the borrow into each bit in br[3:0] and the borrow out
    // of the slice in br[4].
    function automatic logic [4:0] borrow_lookahead(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       bi
    );
        logic [4:0] br;
        br[0] = bi;
        br[1] = g[0] | (p[0] & bi);
        br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
        br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & bi);
        br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bi);
        return br;
    endfunction

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic             borrow_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             zero_r;
    logic             ovf_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [3:0]       g_s;
    logic [3:0]       p_s;
    logic [4:0]       br_s;
    logic [3:0]       diff_nib_s;
    logic [WIDTH-1:0] diff_merge_s;
    logic             ovf_s;

    // Select the operand nibble that the slice counter addresses.
    always_comb begin
        a_nib_s = 4'b0000;
        b_nib_s = 4'b0000;
        for (int k = 0; k < NSLICE; k++) begin
            a_nib_s = a_nib_s | (a_r[4*k +: 4] & {4{cnt_r == CW'(k)}});
            b_nib_s = b_nib_s | (b_r[4*k +: 4] & {4{cnt_r == CW'(k)}});
        end
    end

    // Compute one borrow-lookahead slice from the latched running borrow.
    always_comb begin
        g_s        = ~a_nib_s & b_nib_s;
        p_s        = ~(a_nib_s ^ b_nib_s);
        br_s       = borrow_lookahead(g_s, p_s, borrow_r);
        diff_nib_s = a_nib_s ^ b_nib_s ^ br_s[3:0];
    end

    // Merge the new nibble into the result and derive the signed-overflow flag.
    // The zero and ovf flags use this merged value, so they see the last nibble.
    always_comb begin
        diff_merge_s = diff_r;
        for (int k = 0; k < NSLICE; k++) begin
            diff_merge_s[4*k +: 4] = (cnt_r == CW'(k)) ? diff_nib_s : diff_r[4*k +: 4];
        end
        ovf_s = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_merge_s[WIDTH-1] != a_r[WIDTH-1]);
    end

    // Control FSM, operand latches and registered result/handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            borrow_r    <= 1'b0;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            diff_r      <= {WIDTH{1'b0}};
            bout_r      <= 1'b0;
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid_r <= 1'b0;
                    if (in_valid && in_ready_r) begin
                        a_r        <= a;
                        b_r        <= b;
                        borrow_r   <= bin;
                        cnt_r      <= CNT_ZERO;
                        in_ready_r <= 1'b0;
                        state_r    <= CALC;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                CALC: begin
                    in_ready_r <= 1'b0;
                    diff_r     <= diff_merge_s;
                    borrow_r   <= br_s[4];
                    if (cnt_r == CNT_LAST) begin
                        // The last slice sets every result flag together with
                        // out_valid. The consumer never sees partial flags.
                        bout_r      <= br_s[4];
                        zero_r      <= (diff_merge_s == {WIDTH{1'b0}});
                        ovf_r       <= ovf_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r       <= cnt_r + CNT_ONE;
                        out_valid_r <= 1'b0;
                    end
                end
                DONE: begin
                    // The result registers keep their values after hand-off.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign bout      = bout_r;
    assign zero      = zero_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_cla_sub_seq.sv
// Self-checking bench for cla_sub_seq with WIDTH = 16. The bench pushes an
// expected result to a scoreboard queue when the DUT accepts an operand. It
// pops and compares that entry when the DUT presents a result.

module tb_cla_sub_seq;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    cla_sub_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Reference model built from plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        exp_t        m;
        logic [W:0]  full;
        int          sx;
        int          sy;
        int          r;
        full   = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        m.diff = full[W-1:0];
        m.bout = ({1'b0, x} < ({1'b0, y} + {{W{1'b0}}, bi}));
        m.zero = (full[W-1:0] == {W{1'b0}});
        sx     = int'($signed(x));
        sy     = int'($signed(y));
        r      = sx - sy - int'(bi);
        m.ovf  = (r > 32767) || (r < -32768);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present the operands and wait for the accepting edge. Push the expected
    // result when the DUT accepts, then scramble the inputs. The DUT must use
    // only its latched copies.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        int n;
        a        = x;
        b        = y;
        bin      = bi;
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("issue_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        sb.push_back(model(x, y, bi));
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom);
    endtask

    // Wait for out_valid and count edges since the accepting edge.
    // A negative lat skips the latency check.
    task automatic wait_valid(input string tag, input int lat);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (lat >= 0) chk({tag, "_latency"}, 32'(n), 32'(lat));
        else          chk({tag, "_inready_busy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic check_result(input string tag, input exp_t e);
        chk({tag, "_diff"}, 32'(diff), 32'(e.diff));
        chk({tag, "_bout"}, 32'(bout), 32'(e.bout));
        chk({tag, "_zero"}, 32'(zero), 32'(e.zero));
        chk({tag, "_ovf"},  32'(ovf),  32'(e.ovf));
    endtask

    // Hold out_ready low for 'hold' cycles. Then hand the result off, pop the
    // scoreboard entry and compare it.
    task automatic collect(input string tag, input int lat, input int hold);
        exp_t e;
        wait_valid(tag, lat);
        for (int i = 0; i < hold; i++) tick();
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check_result(tag, e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_handoff_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_handoff_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        exp_t      e;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic      rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = {W{1'b0}};
        b         = {W{1'b0}};
        bin       = 1'b0;
        tick();
        tick();
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff",      32'(diff),      32'd0);
        chk("rst_flags",     {29'd0, bout, zero, ovf}, 32'd0);
        rst = 1'b0;
        tick();

        // Directed vectors
        issue(16'h1234, 16'h0234, 1'b0); collect("basic", 4, 0);
        issue(16'h0000, 16'h0001, 1'b0); collect("wrap", 4, 0);
        issue(16'h5555, 16'h5555, 1'b0); collect("equal", 4, 0);
        issue(16'h8000, 16'h0001, 1'b0); collect("ovf_neg", 4, 0);
        issue(16'h7FFF, 16'hFFFF, 1'b0); collect("ovf_pos", 4, 0);
        issue(16'hA5A5, 16'hA5A5, 1'b1); collect("eq_bin", 4, 0);
        chk("eq_bin_direct_diff", 32'(diff), 32'h0000FFFF);

        // Stall in DONE while a second operand waits on in_valid
        issue(16'h0F0F, 16'h0101, 1'b0);
        wait_valid("stall", 4);
        e        = sb[0];
        a        = 16'h4321;
        b        = 16'h1234;
        bin      = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid",    32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready),  32'd0);
            check_result("stall_hold", e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        void'(sb.pop_front());
        chk("stall_release_valid", 32'(out_valid), 32'd0);
        chk("stall_release_ready", 32'(in_ready),  32'd1);
        tick();
        chk("pending_accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        sb.push_back(model(16'h4321, 16'h1234, 1'b1));
        collect("pending", 4, 0);

        // Reset asserted at slice 2 aborts the operation
        issue(16'hFFFF, 16'h0001, 1'b0);
        void'(sb.pop_front());
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_diff",      32'(diff),      32'd0);
        chk("abort_flags",     {29'd0, bout, zero, ovf}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_result", 32'(out_valid), 32'd0);
        end
        issue(16'h00FF, 16'h000F, 1'b1); collect("after_abort", 4, 0);
        issue(16'h1000, 16'h0FFF, 1'b1); collect("borrow_chain", 4, 0);

        // Random operands with random hold times
        for (int i = 0; i < 1000; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rb = 1'($urandom);
            if (i % 10 == 0) ry = rx;
            issue(rx, ry, rb);
            collect("rand", 4, int'($urandom_range(0, 2)));
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
